// File: rtl/async_fifo.sv
// Single-clock FIFO of 2**ASIZE words with first-word fall-through reads and
// registered full/almost-full/empty/almost-empty flags.
module async_fifo #(
    parameter int DSIZE = 32,
    parameter int ASIZE = 4
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    output logic             wfull,
    output logic             awfull,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty,
    output logic             arempty
);

    localparam int DEPTH = 1 << ASIZE;
    localparam logic [ASIZE:0] OCC_FULL  = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0] OCC_AFULL = (ASIZE+1)'(DEPTH - 1);
    localparam logic [ASIZE:0] OCC_ONE   = (ASIZE+1)'(1);

    logic [DSIZE-1:0] mem_q [DEPTH];

    logic [ASIZE:0] wptr_q, wptr_d;
    logic [ASIZE:0] rptr_q, rptr_d;
    logic [ASIZE:0] occ_d;
    logic           wfull_q, wfull_d;
    logic           awfull_q, awfull_d;
    logic           rempty_q, rempty_d;
    logic           arempty_q, arempty_d;
    logic           wen, ren;

    // Flags are derived from the next-state occupancy so they are valid
    // in the same cycle the pointers settle.
    always_comb begin
        wen       = winc & ~wfull_q & wrst_n;
        ren       = rinc & ~rempty_q & wrst_n;
        wptr_d    = wptr_q + {{ASIZE{1'b0}}, wen};
        rptr_d    = rptr_q + {{ASIZE{1'b0}}, ren};
        occ_d     = wptr_d - rptr_d;
        wfull_d   = (occ_d == OCC_FULL);
        awfull_d  = (occ_d == OCC_AFULL);
        rempty_d  = (occ_d == '0);
        arempty_d = (occ_d == OCC_ONE);
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            wfull_q   <= 1'b0;
            awfull_q  <= 1'b0;
            rempty_q  <= 1'b1;
            arempty_q <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            wfull_q   <= wfull_d;
            awfull_q  <= awfull_d;
            rempty_q  <= rempty_d;
            arempty_q <= arempty_d;
        end
    end

    always_ff @(posedge wclk) begin
        if (wen) begin
            mem_q[wptr_q[ASIZE-1:0]] <= wdata;
        end
    end

    assign rdata   = mem_q[rptr_q[ASIZE-1:0]];
    assign wfull   = wfull_q;
    assign awfull  = awfull_q;
    assign rempty  = rempty_q;
    assign arempty = arempty_q;

endmodule

// File: tb/tb_async_fifo.sv
// Directed self-checking bench for async_fifo: reset, fall-through, ordering,
// full/empty protection, simultaneous access across wrap, mid-run reset.
module tb_async_fifo;

    localparam int DSIZE = 32;
    localparam int ASIZE = 4;

    logic             wclk = 1'b0;
    logic             wrst_n;
    logic             winc;
    logic [DSIZE-1:0] wdata;
    logic             wfull;
    logic             awfull;
    logic             rinc;
    logic [DSIZE-1:0] rdata;
    logic             rempty;
    logic             arempty;

    int checks = 0;
    int errors = 0;

    async_fifo #(
        .DSIZE(DSIZE),
        .ASIZE(ASIZE)
    ) dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .winc   (winc),
        .wdata  (wdata),
        .wfull  (wfull),
        .awfull (awfull),
        .rinc   (rinc),
        .rdata  (rdata),
        .rempty (rempty),
        .arempty(arempty)
    );

    always #5 wclk = ~wclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic flags(input string tag, input logic f, input logic af,
                         input logic e, input logic ae);
        check({tag, ".wfull"},   32'(wfull),   32'(f));
        check({tag, ".awfull"},  32'(awfull),  32'(af));
        check({tag, ".rempty"},  32'(rempty),  32'(e));
        check({tag, ".arempty"}, 32'(arempty), 32'(ae));
    endtask

    // Drive one clock cycle of stimulus; inputs change and outputs are
    // sampled at the falling edge, away from the active edge.
    task automatic cycle(input logic w, input logic [31:0] d, input logic r);
        winc  = w;
        wdata = d;
        rinc  = r;
        @(negedge wclk);
        winc = 1'b0;
        rinc = 1'b0;
    endtask

    task automatic push(input logic [31:0] d);
        cycle(1'b1, d, 1'b0);
    endtask

    task automatic pop_check(input string tag, input logic [31:0] exp);
        check({tag, ".rdata"}, rdata, exp);
        check({tag, ".nonempty"}, 32'(rempty), 32'd0);
        cycle(1'b0, 32'd0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        wrst_n = 1'b0;
        winc   = 1'b0;
        rinc   = 1'b0;
        wdata  = '0;
        repeat (4) @(negedge wclk);
        wrst_n = 1'b1;
        repeat (2) @(negedge wclk);
        flags("idle", 1'b0, 1'b0, 1'b1, 1'b0);

        // Single word fall-through
        push(32'hA);
        flags("single", 1'b0, 1'b0, 1'b0, 1'b1);
        check("single.rdata", rdata, 32'hA);
        cycle(1'b0, 32'd0, 1'b1);
        flags("single_pop", 1'b0, 1'b0, 1'b1, 1'b0);

        // Burst ordering with rinc held
        for (int i = 0; i < 10; i++) push(32'(i));
        for (int i = 0; i < 10; i++) pop_check("burst", 32'(i));
        flags("burst_end", 1'b0, 1'b0, 1'b1, 1'b0);

        // Fill to almost-full, full, then an ignored 17th write
        for (int i = 0; i < 15; i++) push(32'(i));
        flags("afull", 1'b0, 1'b1, 1'b0, 1'b0);
        push(32'd15);
        flags("full", 1'b1, 1'b0, 1'b0, 1'b0);
        push(32'd99);
        flags("full_drop", 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) pop_check("drain", 32'(i));
        flags("drain_end", 1'b0, 1'b0, 1'b1, 1'b0);

        // Read while empty must not move the read pointer
        cycle(1'b0, 32'd0, 1'b1);
        flags("empty_rd", 1'b0, 1'b0, 1'b1, 1'b0);
        push(32'h55);
        flags("empty_rd_push", 1'b0, 1'b0, 1'b0, 1'b1);
        pop_check("empty_rd_data", 32'h55);

        // Simultaneous read/write with 8 stored, across pointer wrap
        for (int i = 0; i < 8; i++) push(32'(100 + i));
        for (int i = 0; i < 20; i++) begin
            check("simul.rdata", rdata, (i < 8) ? 32'(100 + i) : 32'(200 + i - 8));
            cycle(1'b1, 32'(200 + i), 1'b1);
        end
        flags("simul_occ", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 12; i < 20; i++) pop_check("simul_drain", 32'(200 + i));
        flags("simul_end", 1'b0, 1'b0, 1'b1, 1'b0);

        // Simultaneous access when full: only the read is accepted
        for (int i = 0; i < 16; i++) push(32'(300 + i));
        flags("full2", 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'd77, 1'b1);
        flags("full_rw", 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 16; i++) pop_check("full_rw_drain", 32'(300 + i));
        flags("full_rw_end", 1'b0, 1'b0, 1'b1, 1'b0);

        // Simultaneous access when empty: only the write is accepted
        cycle(1'b1, 32'd88, 1'b1);
        flags("empty_rw", 1'b0, 1'b0, 1'b0, 1'b1);
        pop_check("empty_rw_data", 32'd88);
        flags("empty_rw_end", 1'b0, 1'b0, 1'b1, 1'b0);

        // Mid-operation reset discards contents
        for (int i = 1; i <= 5; i++) push(32'(i));
        wrst_n = 1'b0;
        @(negedge wclk);
        wrst_n = 1'b1;
        flags("midrst", 1'b0, 1'b0, 1'b1, 1'b0);
        push(32'd7);
        flags("midrst_push", 1'b0, 1'b0, 1'b0, 1'b1);
        pop_check("midrst_data", 32'd7);
        flags("midrst_end", 1'b0, 1'b0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
